// File: rtl/memory_controller.sv
// Byte-wide RAM/IO port sequencer shared by instruction fetch and the load/store buffer.
// Splits 1/2/4-byte accesses into per-byte RAM cycles and reassembles reads little-endian.
module memory_controller #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,

    input  logic                  io_buffer_full,

    input  logic                  lsb_signal,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_len,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_dout,
    output logic [31:0]           lsb_din,
    output logic                  lsb_done,

    input  logic                  if_signal,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_din,
    output logic                  if_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_LSB = 1'b0,
        OWN_IF  = 1'b1
    } owner_t;

    state_t                state;
    owner_t                owner;
    owner_t                last_grant;
    logic [2:0]            cnt;
    logic [2:0]            n;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           wdata;
    logic [31:0]           rdata;

    logic                  lsb_req;
    logic                  if_req;
    logic                  can_grant;
    logic                  grant_lsb;
    logic                  grant_if;
    logic [2:0]            lsb_n;
    logic                  stall;
    logic [2:0]            cnt_inc;
    logic                  more_bytes;
    logic [ADDR_WIDTH-1:0] next_a;
    logic [1:0]            cap_idx;
    logic [31:0]           rdata_cap;
    logic [1:0]            widx;
    logic [7:0]            wbyte_next;

    // Reads are speculative and may be killed by clear; stores are never blocked by it.
    always_comb begin
        lsb_req   = lsb_signal & (lsb_wr | ~clear);
        if_req    = if_signal & ~clear;
        can_grant = ~lsb_done & ~if_done;
        grant_lsb = can_grant & lsb_req & (~if_req | (last_grant == OWN_IF));
        grant_if  = can_grant & if_req & ~grant_lsb;
    end

    always_comb begin
        case (lsb_len)
            2'd0:    lsb_n = 3'd1;
            2'd1:    lsb_n = 3'd2;
            default: lsb_n = 3'd4;
        endcase
    end

    // Per-byte sequencing helpers: next address, read capture slot, next store byte.
    always_comb begin
        cnt_inc    = cnt + 3'd1;
        more_bytes = (cnt_inc < n);
        next_a     = base + ADDR_WIDTH'(cnt_inc);
        cap_idx    = 2'(cnt - 3'd1);
        rdata_cap  = rdata;
        if (cnt != 3'd0) begin
            rdata_cap[{cap_idx, 3'b000} +: 8] = mem_din;
        end
        widx       = 2'(cnt_inc);
        wbyte_next = wdata[{widx, 3'b000} +: 8];
    end

    // IO stores wait for room in the IO buffer; pausing also suppresses the strobe.
    always_comb begin
        stall  = io_buffer_full & (mem_a >= IO_BASE);
        mem_wr = (state == WRITE) & rdy_in & ~stall;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            owner      <= OWN_LSB;
            last_grant <= OWN_IF;
            cnt        <= 3'd0;
            n          <= 3'd0;
            base       <= '0;
            wdata      <= 32'h0;
            rdata      <= 32'h0;
            mem_a      <= '0;
            mem_dout   <= 8'h00;
            lsb_din    <= 32'h0;
            if_din     <= 32'h0;
            lsb_done   <= 1'b0;
            if_done    <= 1'b0;
        end else if (rdy_in) begin
            lsb_done <= 1'b0;
            if_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_lsb) begin
                        owner      <= OWN_LSB;
                        last_grant <= OWN_LSB;
                        base       <= lsb_addr;
                        mem_a      <= lsb_addr;
                        n          <= lsb_n;
                        cnt        <= 3'd0;
                        wdata      <= lsb_dout;
                        rdata      <= 32'h0;
                        mem_dout   <= lsb_wr ? lsb_dout[7:0] : 8'h00;
                        state      <= lsb_wr ? WRITE : READ;
                    end else if (grant_if) begin
                        owner      <= OWN_IF;
                        last_grant <= OWN_IF;
                        base       <= if_addr;
                        mem_a      <= if_addr;
                        n          <= 3'd4;
                        cnt        <= 3'd0;
                        wdata      <= 32'h0;
                        rdata      <= 32'h0;
                        mem_dout   <= 8'h00;
                        state      <= READ;
                    end
                end

                // Address byte cnt while capturing byte cnt-1; one trailing cycle for the last byte.
                READ: begin
                    if (clear) begin
                        state <= IDLE;
                        mem_a <= '0;
                    end else begin
                        rdata <= rdata_cap;
                        cnt   <= cnt_inc;
                        if (cnt == n) begin
                            state <= IDLE;
                            mem_a <= '0;
                            if (owner == OWN_LSB) begin
                                lsb_din  <= rdata_cap;
                                lsb_done <= 1'b1;
                            end else begin
                                if_din  <= rdata_cap;
                                if_done <= 1'b1;
                            end
                        end else if (more_bytes) begin
                            mem_a <= next_a;
                        end else begin
                            mem_a <= '0;
                        end
                    end
                end

                WRITE: begin
                    if (!stall) begin
                        if (more_bytes) begin
                            cnt      <= cnt_inc;
                            mem_a    <= next_a;
                            mem_dout <= wbyte_next;
                        end else begin
                            state    <= IDLE;
                            mem_a    <= '0;
                            mem_dout <= 8'h00;
                            lsb_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    mem_a <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: byte-wide RAM model plus per-scenario checks
// against hand-computed addresses, data and done timing.
module tb_memory_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full;
    logic        lsb_signal;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_dout;
    logic [31:0] lsb_din;
    logic        lsb_done;
    logic        if_signal;
    logic [31:0] if_addr;
    logic [31:0] if_din;
    logic        if_done;

    int passed = 0;
    int total  = 0;

    logic [7:0] ram [logic [31:0]];

    memory_controller dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .clear         (clear),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_full),
        .lsb_signal    (lsb_signal),
        .lsb_wr        (lsb_wr),
        .lsb_len       (lsb_len),
        .lsb_addr      (lsb_addr),
        .lsb_dout      (lsb_dout),
        .lsb_din       (lsb_din),
        .lsb_done      (lsb_done),
        .if_signal     (if_signal),
        .if_addr       (if_addr),
        .if_din        (if_din),
        .if_done       (if_done)
    );

    always #5 clk = ~clk;

    // Power-on contents: the instruction word 0x00000513 at 0x1000.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h1000: init_byte = 8'h13;
            32'h1001: init_byte = 8'h05;
            default:  init_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [31:0] a);
        rd = ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    // RAM: write on mem_wr, read data valid the cycle after its address.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= rd(mem_a);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
        lsb_signal = 1'b0; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h0; lsb_dout = 32'h0;
        if_signal = 1'b0; if_addr = 32'h0;
        #2;
        total++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a got %h want %h", mem_a, 32'h0); else passed++;
        total++; if (mem_dout !== 8'h0) $display("FAIL reset_mem_dout got %h want %h", mem_dout, 8'h0); else passed++;
        total++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr got %b want 0", mem_wr); else passed++;
        total++; if (lsb_din !== 32'h0) $display("FAIL reset_lsb_din got %h want 0", lsb_din); else passed++;
        total++; if (if_din !== 32'h0) $display("FAIL reset_if_din got %h want 0", if_din); else passed++;
        total++; if (lsb_done !== 1'b0 || if_done !== 1'b0)
            $display("FAIL reset_done got %b%b want 00", lsb_done, if_done); else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_fetch();
        next_cycle();
        if_signal = 1'b1; if_addr = 32'h1000;
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); #1;
            total++; if (mem_a !== 32'h1000 + 32'(c - 1))
                $display("FAIL fetch_addr_c%0d got %h want %h", c, mem_a, 32'h1000 + 32'(c - 1)); else passed++;
            total++; if (if_done !== 1'b0 || mem_wr !== 1'b0)
                $display("FAIL fetch_busy_c%0d got done=%b wr=%b want 0 0", c, if_done, mem_wr); else passed++;
        end
        next_cycle(); #1;
        total++; if (mem_a !== 32'h0 || if_done !== 1'b0)
            $display("FAIL fetch_c5 got a=%h done=%b want 0 0", mem_a, if_done); else passed++;
        next_cycle(); #1;
        total++; if (if_done !== 1'b1) $display("FAIL fetch_done got %b want 1", if_done); else passed++;
        total++; if (if_din !== 32'h00000513) $display("FAIL fetch_data got %h want %h", if_din, 32'h00000513); else passed++;
        if_signal = 1'b0;
        next_cycle(); #1;
        total++; if (if_done !== 1'b0 || if_din !== 32'h00000513)
            $display("FAIL fetch_hold got done=%b data=%h want 0 00000513", if_done, if_din); else passed++;
    endtask

    task automatic test_store_load();
        next_cycle();
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd1; lsb_addr = 32'h2002; lsb_dout = 32'hAABBCCDD;
        next_cycle(); #1;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h2002 || mem_dout !== 8'hDD)
            $display("FAIL store_b0 got wr=%b a=%h d=%h want 1 00002002 dd", mem_wr, mem_a, mem_dout); else passed++;
        next_cycle(); #1;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h2003 || mem_dout !== 8'hCC)
            $display("FAIL store_b1 got wr=%b a=%h d=%h want 1 00002003 cc", mem_wr, mem_a, mem_dout); else passed++;
        next_cycle(); #1;
        total++; if (lsb_done !== 1'b1 || mem_wr !== 1'b0)
            $display("FAIL store_done got done=%b wr=%b want 1 0", lsb_done, mem_wr); else passed++;
        lsb_signal = 1'b0;
        next_cycle();
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h2003;
        next_cycle(); #1;
        total++; if (mem_a !== 32'h2003 || mem_wr !== 1'b0)
            $display("FAIL load_addr got a=%h wr=%b want 00002003 0", mem_a, mem_wr); else passed++;
        next_cycle(); #1;
        total++; if (lsb_done !== 1'b0) $display("FAIL load_early got %b want 0", lsb_done); else passed++;
        next_cycle(); #1;
        total++; if (lsb_done !== 1'b1 || lsb_din !== 32'h000000CC)
            $display("FAIL load_done got done=%b data=%h want 1 000000cc", lsb_done, lsb_din); else passed++;
        lsb_signal = 1'b0;
    endtask

    task automatic test_arbitration();
        next_cycle();
        rst = 1'b1; #1 rst = 1'b0;
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h2003;
        if_signal = 1'b1; if_addr = 32'h1000;
        for (int c = 1; c <= 14; c++) begin
            next_cycle(); #1;
            case (c)
                1: begin total++; if (mem_a !== 32'h2003)
                    $display("FAIL arb_first_lsb got %h want 00002003", mem_a); else passed++; end
                3: begin total++; if (lsb_done !== 1'b1 || if_done !== 1'b0 || lsb_din !== 32'h000000CC)
                    $display("FAIL arb_lsb_done got l=%b i=%b d=%h want 1 0 000000cc", lsb_done, if_done, lsb_din); else passed++; end
                4: begin total++; if (mem_a !== 32'h0)
                    $display("FAIL arb_no_grant_in_done got %h want 0", mem_a); else passed++; end
                5: begin total++; if (mem_a !== 32'h1000)
                    $display("FAIL arb_second_if got %h want 00001000", mem_a); else passed++; end
                10: begin total++; if (if_done !== 1'b1 || lsb_done !== 1'b0 || if_din !== 32'h00000513)
                    $display("FAIL arb_if_done got i=%b l=%b d=%h want 1 0 00000513", if_done, lsb_done, if_din); else passed++; end
                11: begin total++; if (mem_a !== 32'h0)
                    $display("FAIL arb_no_grant_in_done2 got %h want 0", mem_a); else passed++; end
                12: begin total++; if (mem_a !== 32'h2003)
                    $display("FAIL arb_third_lsb got %h want 00002003", mem_a); else passed++; end
                14: begin total++; if (lsb_done !== 1'b1 || if_done !== 1'b0)
                    $display("FAIL arb_lsb_done2 got l=%b i=%b want 1 0", lsb_done, if_done); else passed++; end
                default: ;
            endcase
        end
        lsb_signal = 1'b0; if_signal = 1'b0;
    endtask

    task automatic test_io_stall();
        next_cycle();
        io_full = 1'b1;
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h30000; lsb_dout = 32'h0000005A;
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); #1;
            total++; if (mem_wr !== 1'b0 || mem_a !== 32'h30000)
                $display("FAIL io_stall_c%0d got wr=%b a=%h want 0 00030000", c, mem_wr, mem_a); else passed++;
        end
        next_cycle();
        io_full = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b1 || mem_dout !== 8'h5A)
            $display("FAIL io_write got wr=%b d=%h want 1 5a", mem_wr, mem_dout); else passed++;
        next_cycle(); #1;
        total++; if (lsb_done !== 1'b1 || mem_wr !== 1'b0)
            $display("FAIL io_done got done=%b wr=%b want 1 0", lsb_done, mem_wr); else passed++;
        total++; if (rd(32'h30000) !== 8'h5A)
            $display("FAIL io_ram got %h want 5a", rd(32'h30000)); else passed++;
        lsb_signal = 1'b0;
    endtask

    task automatic test_rdy_pause();
        next_cycle();
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h6000; lsb_dout = 32'h00000077;
        next_cycle();
        rdy = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b0 || mem_a !== 32'h6000)
            $display("FAIL rdy_pause got wr=%b a=%h want 0 00006000", mem_wr, mem_a); else passed++;
        next_cycle();
        rdy = 1'b1;
        #1;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h6000 || mem_dout !== 8'h77)
            $display("FAIL rdy_resume got wr=%b a=%h d=%h want 1 00006000 77", mem_wr, mem_a, mem_dout); else passed++;
        next_cycle(); #1;
        total++; if (lsb_done !== 1'b1) $display("FAIL rdy_done got %b want 1", lsb_done); else passed++;
        lsb_signal = 1'b0;
    endtask

    task automatic test_clear_fetch();
        next_cycle();
        if_signal = 1'b1; if_addr = 32'h1000;
        next_cycle(); #1;
        total++; if (mem_a !== 32'h1000) $display("FAIL clr_fetch_c1 got %h want 00001000", mem_a); else passed++;
        next_cycle();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0; if_signal = 1'b0;
        #1;
        total++; if (mem_a !== 32'h0 || if_done !== 1'b0)
            $display("FAIL clr_fetch_abort got a=%h done=%b want 0 0", mem_a, if_done); else passed++;
        for (int c = 4; c <= 7; c++) begin
            next_cycle(); #1;
            total++; if (if_done !== 1'b0 || mem_a !== 32'h0)
                $display("FAIL clr_fetch_c%0d got done=%b a=%h want 0 0", c, if_done, mem_a); else passed++;
        end
    endtask

    task automatic test_clear_store();
        logic [31:0] d;
        d = 32'h11223344;
        next_cycle();
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h4000; lsb_dout = d;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            clear = 1'b1;
            #1;
            total++; if (mem_wr !== 1'b1 || mem_a !== 32'h4000 + 32'(k) || mem_dout !== d[8*k +: 8])
                $display("FAIL clr_store_b%0d got wr=%b a=%h d=%h want 1 %h %h",
                         k, mem_wr, mem_a, mem_dout, 32'h4000 + 32'(k), d[8*k +: 8]); else passed++;
        end
        next_cycle();
        clear = 1'b0;
        #1;
        total++; if (lsb_done !== 1'b1) $display("FAIL clr_store_done got %b want 1", lsb_done); else passed++;
        lsb_signal = 1'b0;
        next_cycle(); #1;
        total++; if (rd(32'h4003) !== 8'h11) $display("FAIL clr_store_ram got %h want 11", rd(32'h4003)); else passed++;
    endtask

    task automatic test_reset_mid_write();
        next_cycle();
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2; lsb_addr = 32'h5000; lsb_dout = 32'hDEADBEEF;
        next_cycle(); #1;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h5000)
            $display("FAIL rmw_first got wr=%b a=%h want 1 00005000", mem_wr, mem_a); else passed++;
        next_cycle();
        rst = 1'b1;
        lsb_signal = 1'b0;
        #1;
        total++; if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0)
            $display("FAIL rmw_port got a=%h d=%h wr=%b want 0 0 0", mem_a, mem_dout, mem_wr); else passed++;
        total++; if (lsb_done !== 1'b0 || lsb_din !== 32'h0 || if_din !== 32'h0)
            $display("FAIL rmw_regs got done=%b ld=%h id=%h want 0 0 0", lsb_done, lsb_din, if_din); else passed++;
        next_cycle();
        rst = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            #1;
            total++; if (mem_wr !== 1'b0) $display("FAIL rmw_no_write_c%0d got %b want 0", c, mem_wr); else passed++;
            next_cycle();
        end
        total++; if (rd(32'h5000) !== 8'hEF || rd(32'h5001) !== 8'h00)
            $display("FAIL rmw_ram got %h %h want ef 00", rd(32'h5000), rd(32'h5001)); else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_io_stall();
        test_rdy_pause();
        test_clear_fetch();
        test_clear_store();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
